zeroheti_dbg_sba_bridge: RTL and testbench

Downstream of the debug module's OBI system-bus master port. Converts its single-outstanding OBI requests into requests on the zeroHETI system OBI crossbar. Adds address-window decode, a response timeout and a drain mechanism so the debugger never hangs on a wedged slave. Decode and timeout failures are reported on the DM's "other error" input; slave bus errors are reported on its bus-error input.

---
 rtl/zeroheti_dbg_sba_bridge.sv | 148 ++++++++++++++
 tb/tb_zeroheti_dbg_sba_bridge.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zeroheti_dbg_sba_bridge.sv
// Bridge from the debug module's OBI system-bus master to the zeroHETI system crossbar.
// Adds an address-window check, a response timeout and a drain state so the debugger never hangs.
module zeroheti_dbg_sba_bridge #(
   parameter int unsigned           AddrWidth     = 32,
   parameter int unsigned           DataWidth     = 32,
   parameter logic [AddrWidth-1:0]  AddrBase      = 32'h0000_0000,
   parameter logic [AddrWidth-1:0]  AddrSize      = 32'h0010_0000,
   parameter int unsigned           TimeoutCycles = 1024,
   parameter logic [DataWidth-1:0]  ErrRdata      = 32'hBADC_AB1E
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   dm_req_i,
   output logic                   dm_gnt_o,
   input  logic [AddrWidth-1:0]   dm_addr_i,
   input  logic                   dm_we_i,
   input  logic [DataWidth/8-1:0] dm_be_i,
   input  logic [DataWidth-1:0]   dm_wdata_i,
   output logic                   dm_rvalid_o,
   output logic [DataWidth-1:0]   dm_rdata_o,
   output logic                   dm_err_o,
   output logic                   dm_other_err_o,
   output logic                   obi_req_o,
   input  logic                   obi_gnt_i,
   output logic [AddrWidth-1:0]   obi_addr_o,
   output logic                   obi_we_o,
   output logic [DataWidth/8-1:0] obi_be_o,
   output logic [DataWidth-1:0]   obi_wdata_o,
   input  logic                   obi_rvalid_i,
   input  logic [DataWidth-1:0]   obi_rdata_i,
   input  logic                   obi_err_i,
   output logic                   timeout_o
);

   localparam int unsigned           CntWidth = $clog2(TimeoutCycles);
   localparam logic [CntWidth-1:0]   CntLast  = CntWidth'(TimeoutCycles - 1);

   typedef enum logic [2:0] {IDLE, REQ, RESP, LERR, DRAIN} state_t;

   state_t              state;
   logic [CntWidth-1:0] cnt;
   logic [AddrWidth:0]  offset;
   logic                in_window;
   logic                expired;

   // One extra bit keeps addresses below AddrBase from wrapping into the window.
   assign offset    = {1'b0, dm_addr_i} - {1'b0, AddrBase};
   assign in_window = ~offset[AddrWidth] && (offset < {1'b0, AddrSize});
   assign expired   = (cnt == CntLast);
   assign dm_gnt_o  = (state == IDLE) && dm_req_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state          <= IDLE;
         cnt            <= '0;
         obi_req_o      <= 1'b0;
         obi_addr_o     <= '0;
         obi_we_o       <= 1'b0;
         obi_be_o       <= '0;
         obi_wdata_o    <= '0;
         dm_rvalid_o    <= 1'b0;
         dm_rdata_o     <= '0;
         dm_err_o       <= 1'b0;
         dm_other_err_o <= 1'b0;
         timeout_o      <= 1'b0;
      end else begin
         dm_rvalid_o    <= 1'b0;
         dm_rdata_o     <= '0;
         dm_err_o       <= 1'b0;
         dm_other_err_o <= 1'b0;
         timeout_o      <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (dm_req_i) begin
                  obi_addr_o  <= dm_addr_i;
                  obi_we_o    <= dm_we_i;
                  obi_be_o    <= dm_be_i;
                  obi_wdata_o <= dm_wdata_i;
                  if (in_window) begin
                     obi_req_o <= 1'b1;
                     state     <= REQ;
                  end else begin
                     // Decode errors answer during the LERR cycle itself.
                     dm_rvalid_o    <= 1'b1;
                     dm_other_err_o <= 1'b1;
                     dm_rdata_o     <= ErrRdata;
                     state          <= LERR;
                  end
               end
            end
            REQ: begin
               if (obi_gnt_i) begin
                  obi_req_o <= 1'b0;
                  cnt       <= '0;
                  state     <= RESP;
               end else if (expired) begin
                  // Withdrawing req without a grant is intentional: the slave is wedged.
                  obi_req_o      <= 1'b0;
                  cnt            <= '0;
                  dm_rvalid_o    <= 1'b1;
                  dm_other_err_o <= 1'b1;
                  dm_rdata_o     <= ErrRdata;
                  timeout_o      <= 1'b1;
                  state          <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               if (obi_rvalid_i) begin
                  dm_rvalid_o <= 1'b1;
                  dm_err_o    <= obi_err_i;
                  dm_rdata_o  <= obi_err_i ? ErrRdata : obi_rdata_i;
                  cnt         <= '0;
                  state       <= IDLE;
               end else if (expired) begin
                  dm_rvalid_o    <= 1'b1;
                  dm_other_err_o <= 1'b1;
                  dm_rdata_o     <= ErrRdata;
                  timeout_o      <= 1'b1;
                  cnt            <= '0;
                  state          <= DRAIN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            LERR: begin
               state <= IDLE;
            end
            DRAIN: begin
               // The late response belongs to an access already answered, so it is dropped.
               if (obi_rvalid_i || expired) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zeroheti_dbg_sba_bridge.sv
// Directed bench for zeroheti_dbg_sba_bridge with a 16-cycle timeout.
module tb_zeroheti_dbg_sba_bridge;

   localparam logic [31:0] ERR = 32'hBADC_AB1E;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        dm_req_i = 1'b0;
   logic        dm_gnt_o;
   logic [31:0] dm_addr_i = '0;
   logic        dm_we_i = 1'b0;
   logic [3:0]  dm_be_i = '0;
   logic [31:0] dm_wdata_i = '0;
   logic        dm_rvalid_o;
   logic [31:0] dm_rdata_o;
   logic        dm_err_o;
   logic        dm_other_err_o;
   logic        obi_req_o;
   logic        obi_gnt_i = 1'b0;
   logic [31:0] obi_addr_o;
   logic        obi_we_o;
   logic [3:0]  obi_be_o;
   logic [31:0] obi_wdata_o;
   logic        obi_rvalid_i = 1'b0;
   logic [31:0] obi_rdata_i = '0;
   logic        obi_err_i = 1'b0;
   logic        timeout_o;

   int total = 0;
   int bad = 0;
   logic [31:0] outside [2] = '{32'h0010_0000, 32'hFFFF_FFFC};

   zeroheti_dbg_sba_bridge #(.TimeoutCycles(16)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .dm_req_i(dm_req_i), .dm_gnt_o(dm_gnt_o), .dm_addr_i(dm_addr_i), .dm_we_i(dm_we_i),
      .dm_be_i(dm_be_i), .dm_wdata_i(dm_wdata_i), .dm_rvalid_o(dm_rvalid_o),
      .dm_rdata_o(dm_rdata_o), .dm_err_o(dm_err_o), .dm_other_err_o(dm_other_err_o),
      .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
      .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
      .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
      .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_resp(input string tag, input logic [31:0] rv, input logic [31:0] err,
                           input logic [31:0] oerr, input logic [31:0] rd);
      chk({tag, " rvalid"}, 32'(dm_rvalid_o), rv);
      chk({tag, " err"}, 32'(dm_err_o), err);
      chk({tag, " other_err"}, 32'(dm_other_err_o), oerr);
      chk({tag, " rdata"}, dm_rdata_o, rd);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Presents a request in IDLE, checks the grant, and returns one cycle after the grant edge.
   task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd);
      dm_req_i = 1'b1; dm_addr_i = a; dm_we_i = we; dm_be_i = be; dm_wdata_i = wd;
      #1;
      chk("issue gnt", 32'(dm_gnt_o), 1);
      tick;
      dm_req_i = 1'b0;
   endtask

   task automatic run_read(input string tag, input logic [31:0] a, input logic [31:0] rd);
      issue(a, 1'b0, 4'hF, 32'h0);
      chk({tag, " obi_req"}, 32'(obi_req_o), 1);
      chk({tag, " obi_addr"}, obi_addr_o, a);
      obi_gnt_i = 1'b1;
      tick;
      obi_gnt_i = 1'b0; obi_rvalid_i = 1'b1; obi_rdata_i = rd;
      tick;
      obi_rvalid_i = 1'b0; obi_rdata_i = '0;
      chk_resp(tag, 1, 0, 0, rd);
      tick;
   endtask

   initial begin
      tick;
      tick;
      chk("rst rvalid", 32'(dm_rvalid_o), 0);
      chk("rst err", 32'(dm_err_o), 0);
      chk("rst other_err", 32'(dm_other_err_o), 0);
      chk("rst obi_req", 32'(obi_req_o), 0);
      chk("rst timeout", 32'(timeout_o), 0);
      chk("rst obi_addr", obi_addr_o, 0);
      chk("rst rdata", dm_rdata_o, 0);
      chk("rst gnt", 32'(dm_gnt_o), 0);
      rst_ni = 1'b1;
      tick;

      // Normal read: grant on the third REQ cycle, rvalid on the fourth RESP cycle.
      issue(32'h0000_0040, 1'b0, 4'hF, 32'h0);
      chk("t1 obi_req", 32'(obi_req_o), 1);
      chk("t1 obi_addr", obi_addr_o, 32'h0000_0040);
      chk("t1 obi_we", 32'(obi_we_o), 0);
      tick;
      chk("t1 gnt hold", 32'(dm_gnt_o), 0);
      tick;
      obi_gnt_i = 1'b1;
      tick;
      obi_gnt_i = 1'b0;
      chk("t1 req drop", 32'(obi_req_o), 0);
      tick;
      tick;
      tick;
      obi_rvalid_i = 1'b1; obi_rdata_i = 32'h1234_5678;
      chk("t1 early rvalid", 32'(dm_rvalid_o), 0);
      tick;
      obi_rvalid_i = 1'b0; obi_rdata_i = '0;
      chk_resp("t1", 1, 0, 0, 32'h1234_5678);
      chk("t1 timeout", 32'(timeout_o), 0);
      tick;
      chk("t1 single pulse", 32'(dm_rvalid_o), 0);

      // Write with slave error; payload stable while waiting, stray rvalid in REQ ignored.
      issue(32'h0000_0100, 1'b1, 4'b0011, 32'hCAFE_F00D);
      for (int i = 0; i < 3; i++) begin
         chk("t2 obi_req", 32'(obi_req_o), 1);
         chk("t2 obi_addr", obi_addr_o, 32'h0000_0100);
         chk("t2 obi_we", 32'(obi_we_o), 1);
         chk("t2 obi_be", 32'(obi_be_o), 32'h3);
         chk("t2 obi_wdata", obi_wdata_o, 32'hCAFE_F00D);
         chk("t2 no rvalid", 32'(dm_rvalid_o), 0);
         obi_rvalid_i = (i == 1); obi_rdata_i = 32'hDEAD_0000;
         tick;
         obi_rvalid_i = 1'b0;
      end
      chk("t2 stray ignored", 32'(dm_rvalid_o), 0);
      obi_gnt_i = 1'b1;
      tick;
      obi_gnt_i = 1'b0; obi_rvalid_i = 1'b1; obi_err_i = 1'b1; obi_rdata_i = 32'h1111_2222;
      tick;
      obi_rvalid_i = 1'b0; obi_err_i = 1'b0; obi_rdata_i = '0;
      chk_resp("t2", 1, 1, 0, ERR);
      tick;

      // Out-of-window reads answered locally one cycle after grant.
      for (int k = 0; k < 2; k++) begin
         dm_req_i = 1'b1; dm_addr_i = outside[k]; dm_we_i = 1'b0;
         #1;
         chk("t3 gnt", 32'(dm_gnt_o), 1);
         tick;
         chk("t3 obi_req", 32'(obi_req_o), 0);
         chk_resp("t3", 1, 0, 1, ERR);
         chk("t3 gnt in lerr", 32'(dm_gnt_o), 0);
         dm_req_i = 1'b0;
         tick;
         chk("t3 rvalid pulse", 32'(dm_rvalid_o), 0);
         chk("t3 obi_req after", 32'(obi_req_o), 0);
      end
      run_read("t3 last in-window", 32'h000F_FFFC, 32'h0F0F_1234);

      // No grant: req held 16 cycles, then abort.
      issue(32'h0000_0200, 1'b0, 4'hF, 32'h0);
      for (int i = 0; i < 16; i++) begin
         chk("t4 req held", 32'(obi_req_o), 1);
         chk("t4 no timeout", 32'(timeout_o), 0);
         tick;
      end
      chk("t4 req dropped", 32'(obi_req_o), 0);
      chk("t4 timeout", 32'(timeout_o), 1);
      chk_resp("t4", 1, 0, 1, ERR);
      tick;
      chk("t4 timeout pulse", 32'(timeout_o), 0);
      chk("t4 rvalid pulse", 32'(dm_rvalid_o), 0);
      run_read("t4 recover", 32'h0000_0204, 32'h0BAD_F00D);

      // Granted, no response for 16 cycles; late rvalid at cycle 20 is swallowed.
      issue(32'h0000_0300, 1'b0, 4'hF, 32'h0);
      obi_gnt_i = 1'b1;
      tick;
      obi_gnt_i = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("t5 no rvalid", 32'(dm_rvalid_o), 0);
         chk("t5 no timeout", 32'(timeout_o), 0);
         tick;
      end
      chk("t5 timeout", 32'(timeout_o), 1);
      chk_resp("t5", 1, 0, 1, ERR);
      dm_req_i = 1'b1; dm_addr_i = 32'h0000_0400;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t5 drain gnt", 32'(dm_gnt_o), 0);
         tick;
         chk("t5 drain rvalid", 32'(dm_rvalid_o), 0);
         chk("t5 drain timeout", 32'(timeout_o), 0);
      end
      obi_rvalid_i = 1'b1; obi_rdata_i = 32'h0000_0055;
      #1;
      chk("t5 drain gnt late", 32'(dm_gnt_o), 0);
      tick;
      obi_rvalid_i = 1'b0; obi_rdata_i = '0;
      chk("t5 swallowed", 32'(dm_rvalid_o), 0);
      #1;
      chk("t5 idle gnt", 32'(dm_gnt_o), 1);
      dm_req_i = 1'b0;
      tick;
      chk("t5 no second rvalid", 32'(dm_rvalid_o), 0);

      // rvalid on the expiry cycle wins over the timeout.
      issue(32'h0000_0304, 1'b0, 4'hF, 32'h0);
      obi_gnt_i = 1'b1;
      tick;
      obi_gnt_i = 1'b0;
      for (int i = 0; i < 15; i++) tick;
      obi_rvalid_i = 1'b1; obi_rdata_i = 32'hA5A5_0F0F;
      tick;
      obi_rvalid_i = 1'b0; obi_rdata_i = '0;
      chk_resp("t5b", 1, 0, 0, 32'hA5A5_0F0F);
      chk("t5b timeout", 32'(timeout_o), 0);
      tick;
      chk("t5b timeout after", 32'(timeout_o), 0);
      chk("t5b rvalid pulse", 32'(dm_rvalid_o), 0);

      // Reset during RESP discards the access.
      issue(32'h0000_0500, 1'b1, 4'hF, 32'h0000_0077);
      obi_gnt_i = 1'b1;
      tick;
      obi_gnt_i = 1'b0;
      tick;
      rst_ni = 1'b0;
      tick;
      rst_ni = 1'b1;
      chk("t6 obi_req", 32'(obi_req_o), 0);
      chk("t6 obi_addr", obi_addr_o, 0);
      chk("t6 obi_we", 32'(obi_we_o), 0);
      chk("t6 obi_be", 32'(obi_be_o), 0);
      chk("t6 obi_wdata", obi_wdata_o, 0);
      chk("t6 timeout", 32'(timeout_o), 0);
      chk_resp("t6", 0, 0, 0, 0);
      obi_rvalid_i = 1'b1; obi_rdata_i = 32'h0000_0099;
      tick;
      obi_rvalid_i = 1'b0; obi_rdata_i = '0;
      chk("t6 no response", 32'(dm_rvalid_o), 0);
      run_read("t6 recover", 32'h0000_0600, 32'h600D_CAFE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
